// File: rtl/req_capture_8.sv
// Request-capture stage for the 8-to-3 encoder: synchronizes eight async request lines,
// latches their rising edges as pending, and presents one pending request at a time as a one-hot word.
`timescale 1ns/1ps

module req_capture_8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       ack,
    input  logic       clr,
    output logic [7:0] onehot,
    output logic       valid,
    output logic [7:0] pending,
    output logic       overflow
);

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t     state;
    logic [7:0] sync1;
    logic [7:0] sync2;
    logic [7:0] prev;
    logic [7:0] rise;
    logic [7:0] ackmask;
    logic [7:0] grant;

    // The synchronizer and edge detector keep running through clr.
    // That way a level that is already high does not fire a second time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            // NOTE: non-blocking assignments let every flop in the chain sample its predecessor's old value.
            sync1 <= req;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign rise    = sync2 & ~prev;
    assign ackmask = (valid && ack) ? onehot : 8'h00;

    // Highest-index pending bit wins; the ascending scan lets later (higher) bits overwrite.
    always_comb begin
        // NOTE: grant gets a default before the loop so no path leaves it unassigned (no latch).
        grant = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (pending[i]) begin
                grant    = 8'h00;
                grant[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pending  <= '0;
            onehot   <= '0;
            valid    <= 1'b0;
            overflow <= 1'b0;
        end else if (clr) begin
            state    <= IDLE;
            pending  <= '0;
            onehot   <= '0;
            valid    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            // A rise on the bit being acked in this cycle survives the clear.
            pending <= (pending & ~ackmask) | rise;
            if ((rise & pending & ~ackmask) != 8'h00) begin
                overflow <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (pending != 8'h00) begin
                        onehot <= grant;
                        valid  <= 1'b1;
                        state  <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (ack) begin
                        onehot <= '0;
                        valid  <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_req_capture_8.sv
// Self-checking bench for req_capture_8: directed scenarios plus randomized stress
// against a cycle-level behavioural model built from delayed request history.
`timescale 1ns/1ps

module tb_req_capture_8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = 8'h00;
    logic       ack = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] onehot;
    logic       valid;
    logic [7:0] pending;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    // Behavioural model: requests as seen 1, 2 and 3 edges ago, plus pending set and grant.
    logic [7:0] m_h1, m_h2, m_h3;
    logic [7:0] m_pending, m_onehot;
    logic       m_valid, m_overflow;
    int         captured[8];
    int         granted[8];

    req_capture_8 dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .ack      (ack),
        .clr      (clr),
        .onehot   (onehot),
        .valid    (valid),
        .pending  (pending),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int top_bit(input logic [7:0] v);
        int r = -1;
        for (int i = 0; i < 8; i++) if (v[i]) r = i;
        return r;
    endfunction

    function automatic logic [7:0] highest(input logic [7:0] v);
        logic [7:0] r = 8'h00;
        for (int i = 0; i < 8; i++) if (v[i]) r = 8'h01 << i;
        return r;
    endfunction

    task automatic model_reset();
        m_h1 = 8'h00; m_h2 = 8'h00; m_h3 = 8'h00;
        m_pending = 8'h00; m_onehot = 8'h00;
        m_valid = 1'b0; m_overflow = 1'b0;
    endtask

    // A request counts at edge n when it was high at edge n-2 and low at edge n-3.
    task automatic model_edge();
        logic [7:0] rise_v, am, keep;
        rise_v = m_h2 & ~m_h3;
        m_h3 = m_h2; m_h2 = m_h1; m_h1 = req;
        if (clr) begin
            m_pending = 8'h00; m_onehot = 8'h00; m_valid = 1'b0; m_overflow = 1'b0;
        end else begin
            am   = (m_valid && ack) ? m_onehot : 8'h00;
            keep = m_pending & ~am;
            for (int i = 0; i < 8; i++) if (rise_v[i] && !keep[i]) captured[i]++;
            if ((rise_v & keep) != 8'h00) m_overflow = 1'b1;
            if (!m_valid) begin
                if (m_pending != 8'h00) begin
                    m_onehot = highest(m_pending);
                    m_valid  = 1'b1;
                end
            end else if (ack) begin
                m_valid  = 1'b0;
                m_onehot = 8'h00;
            end
            m_pending = keep | rise_v;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drain();
        req = 8'h00;
        ack = 1'b1;
        for (int i = 0; i < 40; i++) step();
        ack = 1'b0;
    endtask

    task automatic test_reset();
        req = 8'hFF;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if (onehot !== 8'h00) begin errors++; $display("FAIL reset_onehot: got %h want 00", onehot); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
        checks++; if (pending !== 8'h00) begin errors++; $display("FAIL reset_pending: got %h want 00", pending); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(); step();
        checks++; if (pending !== 8'h00) begin errors++; $display("FAIL release_pending_early: got %h want 00", pending); end
        step();
        checks++; if (pending !== 8'hFF) begin errors++; $display("FAIL release_pending: got %h want ff", pending); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL release_valid_early: got %b want 0", valid); end
        step();
        checks++; if (valid !== 1'b1 || onehot !== 8'h80) begin errors++; $display("FAIL release_grant: got %b/%h want 1/80", valid, onehot); end
        drain();
        checks++; if (pending !== 8'h00 || valid !== 1'b0) begin errors++; $display("FAIL release_drain: got %h/%b want 00/0", pending, valid); end
    endtask

    task automatic test_single();
        logic [2:0] y;
        req = 8'h04;
        step(); step(); step();
        checks++; if (pending !== 8'h04) begin errors++; $display("FAIL single_pending: got %h want 04", pending); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL single_latency: got valid %b want 0", valid); end
        step();
        checks++; if (valid !== 1'b1 || onehot !== 8'h04) begin errors++; $display("FAIL single_grant: got %b/%h want 1/04", valid, onehot); end
        y = 3'(top_bit(onehot));
        checks++; if (y !== 3'b010) begin errors++; $display("FAIL single_encode: got %b want 010", y); end
        step();
        ack = 1'b1;
        step();
        ack = 1'b0;
        checks++; if (valid !== 1'b0 || onehot !== 8'h00 || pending !== 8'h00) begin
            errors++; $display("FAIL single_ack: got %b/%h/%h want 0/00/00", valid, onehot, pending);
        end
        req = 8'h00;
        step(); step(); step();
    endtask

    task automatic test_priority();
        logic [7:0] exp_seq[3];
        int n;
        exp_seq[0] = 8'h80; exp_seq[1] = 8'h20; exp_seq[2] = 8'h02;
        req = 8'hA2;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            while (!valid && n < 10) begin step(); n++; end
            checks++; if (valid !== 1'b1) begin errors++; $display("FAIL prio_timeout: grant %0d valid %b want 1", k, valid); end
            checks++; if (onehot !== exp_seq[k]) begin errors++; $display("FAIL prio_order: grant %0d got %h want %h", k, onehot, exp_seq[k]); end
            ack = 1'b1;
            step();
            ack = 1'b0;
            checks++; if (valid !== 1'b0) begin errors++; $display("FAIL prio_gap: grant %0d valid %b want 0", k, valid); end
        end
        checks++; if (pending !== 8'h00) begin errors++; $display("FAIL prio_empty: got %h want 00", pending); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL prio_overflow: got %b want 0", overflow); end
        req = 8'h00;
        step(); step(); step();
    endtask

    task automatic test_overflow_set_wins();
        req = 8'h48;
        step(); step(); step(); step();
        checks++; if (valid !== 1'b1 || onehot !== 8'h40) begin errors++; $display("FAIL ovf_grant: got %b/%h want 1/40", valid, onehot); end
        checks++; if (pending !== 8'h48 || overflow !== 1'b0) begin errors++; $display("FAIL ovf_pre: got %h/%b want 48/0", pending, overflow); end
        req = 8'h40;
        step(); step();
        req = 8'h48;
        step(); step(); step(); step();
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        checks++; if (valid !== 1'b1 || onehot !== 8'h40) begin errors++; $display("FAIL ovf_hold: got %b/%h want 1/40", valid, onehot); end
        req = 8'h08;
        step(); step();
        req = 8'h48;
        step(); step();
        ack = 1'b1;
        step();
        ack = 1'b0;
        checks++; if (pending !== 8'h48) begin errors++; $display("FAIL setwins_pending: got %h want 48", pending); end
        checks++; if (valid !== 1'b0 || overflow !== 1'b1) begin errors++; $display("FAIL setwins_flags: got %b/%b want 0/1", valid, overflow); end
        step();
        checks++; if (valid !== 1'b1 || onehot !== 8'h40) begin errors++; $display("FAIL setwins_regrant: got %b/%h want 1/40", valid, onehot); end
        drain();
        checks++; if (pending !== 8'h00) begin errors++; $display("FAIL ovf_drain: got %h want 00", pending); end
    endtask

    task automatic test_clr();
        req = 8'h11;
        step(); step(); step(); step();
        checks++; if (valid !== 1'b1 || onehot !== 8'h10 || pending !== 8'h11) begin
            errors++; $display("FAIL clr_pre: got %b/%h/%h want 1/10/11", valid, onehot, pending);
        end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL clr_pre_overflow: got %b want 1", overflow); end
        clr = 1'b1;
        step();
        clr = 1'b0;
        checks++; if (pending !== 8'h00 || valid !== 1'b0 || onehot !== 8'h00 || overflow !== 1'b0) begin
            errors++; $display("FAIL clr_state: got %h/%b/%h/%b want 00/0/00/0", pending, valid, onehot, overflow);
        end
        for (int i = 0; i < 6; i++) begin
            step();
            checks++; if (valid !== 1'b0 || pending !== 8'h00) begin
                errors++; $display("FAIL clr_no_refire: cycle %0d got %b/%h want 0/00", i, valid, pending);
            end
        end
        req = 8'h00;
        step(); step(); step();
    endtask

    task automatic test_reset_mid_handshake();
        int n = 0;
        req = 8'h01;
        while (!valid && n < 10) begin step(); n++; end
        checks++; if (valid !== 1'b1 || onehot !== 8'h01) begin errors++; $display("FAIL midrst_grant: got %b/%h want 1/01", valid, onehot); end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if (valid !== 1'b0 || onehot !== 8'h00 || pending !== 8'h00) begin
            errors++; $display("FAIL midrst_async: got %b/%h/%h want 0/00/00", valid, onehot, pending);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(); step(); step();
        checks++; if (pending !== 8'h01) begin errors++; $display("FAIL midrst_recapture: got %h want 01", pending); end
        step();
        checks++; if (valid !== 1'b1 || onehot !== 8'h01) begin errors++; $display("FAIL midrst_regrant: got %b/%h want 1/01", valid, onehot); end
        drain();
    endtask

    task automatic test_random();
        int         hold[8];
        logic [7:0] lvl = 8'h00;
        logic [7:0] p_onehot;
        logic       p_valid, p_ack;
        for (int b = 0; b < 8; b++) begin
            hold[b] = int'($urandom_range(2, 7));
            captured[b] = 0;
            granted[b] = 0;
        end
        for (int cyc = 0; cyc < 10000; cyc++) begin
            for (int b = 0; b < 8; b++) begin
                if (hold[b] <= 1) begin
                    lvl[b]  = ~lvl[b];
                    hold[b] = int'($urandom_range(2, 7));
                end else begin
                    hold[b]--;
                end
            end
            req = lvl;
            ack = ($urandom_range(0, 2) == 0);
            p_valid = valid; p_onehot = onehot; p_ack = ack;
            if (valid && ack && onehot != 8'h00) granted[top_bit(onehot)]++;
            step();
            checks++; if (onehot !== m_onehot || valid !== m_valid) begin
                errors++; if (errors <= 20) $display("FAIL rand_grant: cycle %0d got %b/%h want %b/%h", cyc, valid, onehot, m_valid, m_onehot);
            end
            checks++; if (pending !== m_pending) begin
                errors++; if (errors <= 20) $display("FAIL rand_pending: cycle %0d got %h want %h", cyc, pending, m_pending);
            end
            checks++; if (overflow !== m_overflow) begin
                errors++; if (errors <= 20) $display("FAIL rand_overflow: cycle %0d got %b want %b", cyc, overflow, m_overflow);
            end
            checks++; if ($countones(onehot) > 1 || (valid && (onehot & pending) == 8'h00)) begin
                errors++; if (errors <= 20) $display("FAIL rand_onehot: cycle %0d got %h pending %h want one-hot within pending", cyc, onehot, pending);
            end
            if (p_valid && !p_ack) begin
                checks++; if (valid !== 1'b1 || onehot !== p_onehot) begin
                    errors++; if (errors <= 20) $display("FAIL rand_stable: cycle %0d got %b/%h want 1/%h", cyc, valid, onehot, p_onehot);
                end
            end
        end
        req = 8'h00;
        ack = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (valid && onehot != 8'h00) granted[top_bit(onehot)]++;
            step();
        end
        ack = 1'b0;
        for (int b = 0; b < 8; b++) begin
            checks++; if (granted[b] != captured[b]) begin
                errors++; $display("FAIL rand_accounting: bit %0d granted %0d want %0d", b, granted[b], captured[b]);
            end
        end
    endtask

    initial begin
        for (int b = 0; b < 8; b++) begin captured[b] = 0; granted[b] = 0; end
        model_reset();
        test_reset();
        test_single();
        test_priority();
        test_overflow_set_wins();
        test_clr();
        test_reset_mid_handshake();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
